// File: rtl/alu_share_arbiter.sv
// Round-robin sharing of one combinational ALU between two requesters: one
// registered EXEC cycle per op, result/zero/err held per requester.

module alu_share_slot #(
   parameter int DATA_W = 32
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              wr_i,
   input  logic [DATA_W-1:0] result_i,
   input  logic              zero_i,
   input  logic              err_i,
   output logic [DATA_W-1:0] result_o,
   output logic              zero_o,
   output logic              err_o
);
   logic [DATA_W-1:0] result_q;
   logic              zero_q;
   logic              err_q;

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         result_q <= '0;
         zero_q   <= 1'b0;
         err_q    <= 1'b0;
      end else if (wr_i) begin
         result_q <= result_i;
         zero_q   <= zero_i;
         err_q    <= err_i;
      end
   end

   assign result_o = result_q;
   assign zero_o   = zero_q;
   assign err_o    = err_q;
endmodule

module alu_share_arbiter #(
   parameter int DATA_W = 32,
   parameter int CTRL_W = 4
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              req0_valid_i,
   output logic              req0_ready_o,
   input  logic [CTRL_W-1:0] req0_ctrl_i,
   input  logic [DATA_W-1:0] req0_src1_i,
   input  logic [DATA_W-1:0] req0_src2_i,
   output logic              req0_done_o,
   output logic [DATA_W-1:0] req0_result_o,
   output logic              req0_zero_o,
   output logic              req0_err_o,
   input  logic              req1_valid_i,
   output logic              req1_ready_o,
   input  logic [CTRL_W-1:0] req1_ctrl_i,
   input  logic [DATA_W-1:0] req1_src1_i,
   input  logic [DATA_W-1:0] req1_src2_i,
   output logic              req1_done_o,
   output logic [DATA_W-1:0] req1_result_o,
   output logic              req1_zero_o,
   output logic              req1_err_o,
   output logic [CTRL_W-1:0] alu_ctrl_o,
   output logic [DATA_W-1:0] alu_src1_o,
   output logic [DATA_W-1:0] alu_src2_o,
   input  logic [DATA_W-1:0] alu_result_i,
   input  logic              alu_zero_i,
   output logic              busy_o,
   output logic              grant_o
);
   localparam int NREQ = 2;
   localparam logic [CTRL_W-1:0] CTRL_MAX = CTRL_W'(11);

   typedef enum logic [1:0] {IDLE, EXEC, RESP} state_e;

   state_e state_q, state_d;

   logic [NREQ-1:0]             valid, ready, done, wr, zero, err;
   logic [NREQ-1:0][CTRL_W-1:0] ctrl;
   logic [NREQ-1:0][DATA_W-1:0] src1, src2, res;

   logic              win, illegal, accept, sel;
   logic              gnt_q, last_q;
   logic [CTRL_W-1:0] ctrl_q;
   logic [DATA_W-1:0] src1_q, src2_q;
   logic [DATA_W-1:0] wr_result;
   logic              wr_zero, wr_err;

   assign valid = {req1_valid_i, req0_valid_i};
   assign ctrl  = {req1_ctrl_i, req0_ctrl_i};
   assign src1  = {req1_src1_i, req0_src1_i};
   assign src2  = {req1_src2_i, req0_src2_i};

   // On a tie the requester not served last wins; otherwise the lone valid one.
   always_comb begin
      win = valid[1];
      if (&valid) win = ~last_q;
   end

   assign illegal = ctrl[win] > CTRL_MAX;
   assign accept  = (state_q == IDLE) && (|valid);

   always_comb begin
      state_d = state_q;
      ready   = '0;
      case (state_q)
         IDLE: begin
            if (|valid) begin
               ready[win] = 1'b1;
               state_d    = illegal ? RESP : EXEC;
            end
         end
         EXEC:    state_d = RESP;
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state_q <= IDLE;
         gnt_q   <= 1'b0;
         last_q  <= 1'b1;
         ctrl_q  <= '0;
         src1_q  <= '0;
         src2_q  <= '0;
      end else begin
         state_q <= state_d;
         if (accept) begin
            gnt_q  <= win;
            last_q <= win;
            ctrl_q <= ctrl[win];
            src1_q <= src1[win];
            src2_q <= src2[win];
         end
      end
   end

   // EXEC writes the captured ALU result; an illegal accept writes the error record.
   assign sel       = (state_q == EXEC) ? gnt_q : win;
   assign wr_result = (state_q == EXEC) ? alu_result_i : '0;
   assign wr_zero   = (state_q == EXEC) && alu_zero_i;
   assign wr_err    = (state_q != EXEC);

   for (genvar g = 0; g < NREQ; g++) begin : g_slot
      assign wr[g]   = ((state_q == EXEC) || (accept && illegal)) && (sel == 1'(g));
      assign done[g] = (state_q == RESP) && (gnt_q == 1'(g));
      alu_share_slot #(.DATA_W(DATA_W)) u_slot (
         .clk_i    (clk_i),
         .rst_i    (rst_i),
         .wr_i     (wr[g]),
         .result_i (wr_result),
         .zero_i   (wr_zero),
         .err_i    (wr_err),
         .result_o (res[g]),
         .zero_o   (zero[g]),
         .err_o    (err[g])
      );
   end

   assign alu_ctrl_o = (state_q == EXEC) ? ctrl_q : '0;
   assign alu_src1_o = (state_q == EXEC) ? src1_q : '0;
   assign alu_src2_o = (state_q == EXEC) ? src2_q : '0;
   assign busy_o     = (state_q != IDLE);
   assign grant_o    = gnt_q;

   assign req0_ready_o  = ready[0];
   assign req1_ready_o  = ready[1];
   assign req0_done_o   = done[0];
   assign req1_done_o   = done[1];
   assign req0_result_o = res[0];
   assign req1_result_o = res[1];
   assign req0_zero_o   = zero[0];
   assign req1_zero_o   = zero[1];
   assign req0_err_o    = err[0];
   assign req1_err_o    = err[1];
endmodule

// File: doc/alu_share_arbiter.md
# alu_share_arbiter

Two-port arbiter and sequencer that shares the single combinational ALU between two requesters, for example the main datapath and a multi-cycle helper unit. Each requester presents an ALU control code and two operands through a valid/ready handshake. The block grants one request at a time in round-robin order and drives the ALU from registered operands for exactly one cycle. It then returns the captured result and zero flag to the winner with a one-cycle done pulse.

## Interface
- DATA_W, 32, operand/result width
- CTRL_W, 4, ALU control code width
- clk_i  in  1  clock, all state on rising edge
- rst_i  in  1  reset, asynchronous, active-low
- reqN_valid_i  in  1  (N=0,1) request pending
- reqN_ready_o  out  1  request accepted this cycle when high together with valid
- reqN_ctrl_i  in  CTRL_W  ALU control code (0 AND, 1 OR, 2 NAND, 3 NOR, 4 ADDU, 5 SUBU, 6 SLT, 7 EQUAL, 8 SRA, 9 SRAV, 10 LUI, 11 SLTU)
- reqN_src1_i, reqN_src2_i  in  DATA_W  operands
- reqN_done_o  out  1  one-cycle pulse: result for requester N valid
- reqN_result_o  out  DATA_W  last result for requester N, held until its next completion
- reqN_zero_o  out  1  last zero flag for requester N, held likewise
- reqN_err_o  out  1  last completion for N used an illegal control code, held likewise
- alu_ctrl_o  out  CTRL_W  control code to shared ALU
- alu_src1_o, alu_src2_o  out  DATA_W  operands to shared ALU
- alu_result_i  in  DATA_W  ALU result (combinational from alu_* outputs)
- alu_zero_i  in  1  ALU zero flag
- busy_o  out  1  high in EXEC and RESP
- grant_o  out  1  index of the requester currently owning the ALU (valid while busy_o)

## Operation
- FSM states: IDLE, EXEC, RESP. Reset state is IDLE.
- IDLE: winner is the only valid requester. If both are valid, winner is the one not granted last (last_grant register).
  - Winner's ready_o is high combinationally. The loser's ready_o is low.
  - On valid&&ready: latch ctrl, src1, src2 and winner index, update last_grant, then go to EXEC.
  - If ctrl > 11: mark illegal and go directly to RESP. EXEC is skipped.
- EXEC: alu_ctrl_o/src1/src2 driven from latched registers. At the clock edge, alu_result_i and alu_zero_i are captured into the winner's result/zero registers, err is cleared, and the FSM goes to RESP.
- Illegal path: at the IDLE→RESP edge, the winner's result is set to 0, zero to 0 and err to 1.
- RESP: winner's done_o is 1 for exactly this cycle. Next state is IDLE.
- Outside EXEC, alu_ctrl_o, alu_src1_o and alu_src2_o are 0.
- Both ready_o are 0 in EXEC and RESP.
- A requester must hold valid and operands until ready. A valid withdrawn before ready is simply not served.
- The non-winning requester's result, zero and err registers never change during another requester's transaction.
- Requesters cannot back-pressure done. A completion missed by a requester is still reflected in its held result registers.

## Timing
- Reset (rst_i low, asynchronous) forces:
  - state IDLE, last_grant=1 (so requester 0 wins the first tie)
  - all reqN_result_o, reqN_zero_o, reqN_err_o, reqN_done_o at 0
  - alu_* outputs at 0, busy_o=0, grant_o=0
- Reset mid-transaction aborts it: no done pulse and no result update.
- Legal op: accept in cycle T, EXEC in T+1, done_o high in T+2, new accept possible in T+3. Throughput is one op per 3 cycles.
- Illegal op: accept in T, done_o with err high in T+1, new accept possible in T+2.
- reqN_result_o changes at the same edge that raises reqN_done_o.
- Continuous contention alternates grants 0,1,0,1,… with each requester receiving one done every 6 cycles.

## Test plan
- Reset, then req0 only: ADDU (ctrl 4), src1=5, src2=7. Expect ready0 in the accept cycle, alu_ctrl_o=4 with operands 5/7 one cycle later, and done0 two cycles after accept with result0=12, zero0=0, err0=0. result1 stays 0.
- Both valid from reset: req0 SUBU 9-9, req1 OR 0xF0|0x0F. Expect req0 granted first with result0=0 and zero0=1. Then req1 is accepted in the cycle after done0, giving result1=0xFF.
- Both held valid for 4 transactions. Expect grant order 0,1,0,1, done pulses spaced 3 cycles apart, and ready never high for both at once.
- req1 with ctrl=13. Expect done1 one cycle after accept, err1=1, result1=0, and alu_ctrl_o staying 0 throughout. A following legal req1 clears err1.
- Assert rst_i low during EXEC of a req0 SLT. Expect immediate return of all outputs to reset values and no done0. After release, a fresh req0 SLT(-1,1) completes with result0=1.
